sme_host: RTL and testbench
===========================

# sme_host

Host-side transmitter for the string-matching engine's serial load protocol. Software-facing writes fill a local string buffer and a pattern buffer. A `start` command then streams the buffers byte-by-byte onto `chardata` with `isstring` / `ispattern` framing, waits for the engine's `valid` pulse, and latches `match` / `match_index` into result registers. It sits between the testbench/CPU write port and the matching engine. It is the only driver of the engine's input bus.

## Interface
- `STR_DEPTH`, default 32: string buffer capacity in bytes; the engine's `match_index` is 5 bits.
- `PAT_DEPTH`, default 8: pattern buffer capacity in bytes, including `^`, `$` and `.` characters.
- `TIMEOUT_CYC`, default 1024: WAIT-state watchdog limit, used only with `SME_HOST_TIMEOUT_EN`.

Ports:
- `clk`  in  1  sole clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  buffer write strobe.
- `wr_sel`  in  1  buffer select: 0 = string buffer, 1 = pattern buffer.
- `wr_data`  in  8  byte to append.
- `start`  in  1  single-cycle command to transmit the buffers.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse when the result registers update.
- `err`  out  1  one-cycle pulse when `start` is rejected.
- `res_match`  out  1  latched engine `match`.
- `res_index`  out  5  latched engine `match_index`.
- `res_timeout`  out  1  high if the last transaction timed out; constant 0 without the macro.
- `chardata`  out  8  byte to the engine.
- `isstring`  out  1  string byte qualifier.
- `ispattern`  out  1  pattern byte qualifier.
- `valid`  in  1  engine result strobe.
- `match`  in  1  engine match flag.
- `match_index`  in  5  engine match position.

## Operation
States: IDLE, SEND_STR, SEND_PAT, GAP, WAIT, DONE.

- **IDLE**
  - `wr_en` appends `wr_data` at the selected buffer's write pointer and increments that pointer.
  - Length counters: `str_len` is 6 bits, range 0..32; `pat_len` is 4 bits, range 0..8.
  - A write to a full buffer is dropped and its pointer does not wrap.
  - If `start` arrives with `str_len == 0` or `pat_len == 0`: pulse `err` next cycle and stay in IDLE.
  - Otherwise: go to SEND_STR with the read index at 0.
  - If `wr_en` and `start` occur in the same cycle, the write lands first and the start check uses the updated lengths.
- **SEND_STR**
  - Each cycle drives `isstring=1`, `ispattern=0`, `chardata=str[i]`.
  - After beat `str_len-1`, go to SEND_PAT.
- **SEND_PAT**
  - Each cycle drives `ispattern=1`, `isstring=0`, `chardata=pat[j]`.
  - Bytes are sent verbatim: `^` (0x5E), `$` (0x24) and `.` (0x2E) get no special handling here.
  - After beat `pat_len-1`, go to GAP.
- **GAP**
  - One cycle with `isstring=ispattern=0` and `chardata=0`. This is the engine's end-of-load marker.
  - Go to WAIT.
- **WAIT**
  - Qualifiers stay low.
  - On sampling `valid=1`: capture `match` and `match_index`, clear `res_timeout`, go to DONE.
- **DONE**
  - `done=1` for one cycle.
  - Clear `str_len`, `pat_len` and both pointers. Buffer contents are not cleared.
  - Go to IDLE.
- **Write and start rules**
  - `wr_en` outside IDLE is ignored.
  - `start` outside IDLE is ignored; it does not pulse `err`.
  - `valid` outside WAIT is ignored.
- **Output rules**
  - `chardata`, `isstring` and `ispattern` are registered outputs.
  - In every state other than SEND_STR and SEND_PAT, `isstring` and `ispattern` are 0.
  - `isstring` and `ispattern` are never high together.
- **Reset values**
  - All outputs are 0 and the state is IDLE.
  - Lengths and pointers are 0; result registers are 0.
  - Buffer RAM is not reset.
  - Reset asserted mid-transmission aborts within the reset cycle: qualifiers are low the following cycle and no `done` is issued.

## Timing
- `start` sampled at edge t → first string beat on the outputs during cycle t+1.
- String beats occupy cycles t+1 … t+S (S = `str_len`).
- Pattern beats occupy t+S+1 … t+S+P (P = `pat_len`).
- GAP is cycle t+S+P+1; WAIT begins at t+S+P+2.
- `busy` is high from t+1 through the DONE cycle inclusive.
- `valid` sampled at edge v → `res_*` updated and `done=1` during cycle v+1.
- Minimum start-to-done time is S+P+3 cycles.
- A back-to-back `start` is accepted in the first IDLE cycle after DONE.

## Configuration
- `SME_HOST_TIMEOUT_EN` defined:
  - A counter runs in WAIT and clears on entry to WAIT.
  - If it reaches `TIMEOUT_CYC` without `valid`: `res_timeout=1`, `res_match=0`, `res_index=0`, go to DONE and pulse `done`.
- `SME_HOST_TIMEOUT_EN` undefined:
  - No counter exists and WAIT waits indefinitely.
  - `res_timeout` is tied to 0.

## Test plan
- Write "hello world" (11 bytes) and pattern "wor", then `start`; engine model returns `valid` with match=1, index=6.
  - Required: 11 `isstring` beats, then 3 `ispattern` beats (0x77, 0x6F, 0x72), then 1 idle cycle.
  - Required: `done` one cycle after `valid`; `res_match=1`, `res_index=6`; `busy` low the cycle after `done`.
- Pattern "^ab$", string "ab": `chardata` sequence is 0x61, 0x62, then 0x5E, 0x61, 0x62, 0x24.
  - Required: qualifiers framed exactly as described in Operation; no beat carries both qualifiers.
- `start` with `pat_len=0`.
  - Required: `err` pulses at t+1, `busy` stays 0, no qualifier asserted.
- 33 string writes.
  - Required: `str_len=32` and the 33rd byte is dropped; transmission shows exactly 32 string beats.
- Assert `reset` during the 5th string beat.
  - Required: qualifiers low the next cycle, no `done`, lengths 0; a new write/start sequence then completes normally.
- With `SME_HOST_TIMEOUT_EN` and `TIMEOUT_CYC=16`, engine never asserts `valid`.
  - Required: `done` with `res_timeout=1` and `res_match=0` exactly 16 cycles after WAIT entry.

Source files
------------

// File: rtl/sme_host.sv
// Host-side serial loader for the string-matching engine: buffers a string and a pattern,
// streams them with isstring/ispattern framing, then latches the engine result.
// Optional WAIT watchdog is enabled by defining SME_HOST_TIMEOUT_EN.
module sme_host #(
    parameter int unsigned STR_DEPTH   = 32,
    parameter int unsigned PAT_DEPTH   = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [7:0] wr_data,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_timeout,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       valid,
    input  logic       match,
    input  logic [4:0] match_index
);

    localparam int unsigned StrLenW = $clog2(STR_DEPTH + 1);
    localparam int unsigned PatLenW = $clog2(PAT_DEPTH + 1);
    localparam int unsigned StrAw   = $clog2(STR_DEPTH);
    localparam int unsigned PatAw   = $clog2(PAT_DEPTH);

    typedef enum logic [2:0] {
        StIdle, StSendStr, StSendPat, StGap, StWait, StDone
    } state_e;

    state_e             r_state, w_state_nxt;
    logic [7:0]         r_str_mem [STR_DEPTH];
    logic [7:0]         r_pat_mem [PAT_DEPTH];
    logic [StrLenW-1:0] r_str_len, w_str_len_nxt;
    logic [PatLenW-1:0] r_pat_len, w_pat_len_nxt;
    logic [StrLenW-1:0] r_idx, w_idx_nxt, w_idx_inc;
    logic [7:0]         r_chardata, w_chardata_nxt;
    logic               r_isstring, w_isstring_nxt;
    logic               r_ispattern, w_ispattern_nxt;
    logic               r_err, w_err_nxt;
    logic               r_done, w_done_nxt;
    logic               r_res_match;
    logic [4:0]         r_res_index;
    logic               w_str_wr, w_pat_wr, w_cap_valid, w_cap_tmo, w_tmo_hit;

    // Full buffers drop writes; the length doubles as the write pointer.
    assign w_str_wr  = (r_state == StIdle) && wr_en && !wr_sel &&
                       (r_str_len != StrLenW'(STR_DEPTH));
    assign w_pat_wr  = (r_state == StIdle) && wr_en && wr_sel &&
                       (r_pat_len != PatLenW'(PAT_DEPTH));
    assign w_idx_inc = r_idx + StrLenW'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_str_len_nxt   = r_str_len;
        w_pat_len_nxt   = r_pat_len;
        w_chardata_nxt  = 8'h00;
        w_isstring_nxt  = 1'b0;
        w_ispattern_nxt = 1'b0;
        w_err_nxt       = 1'b0;
        w_done_nxt      = 1'b0;
        w_cap_valid     = 1'b0;
        w_cap_tmo       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_str_wr) w_str_len_nxt = r_str_len + StrLenW'(1);
                if (w_pat_wr) w_pat_len_nxt = r_pat_len + PatLenW'(1);
                if (start) begin
                    if (w_str_len_nxt == '0 || w_pat_len_nxt == '0) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = StSendStr;
                        w_idx_nxt      = '0;
                        w_isstring_nxt = 1'b1;
                        // Byte 0 may be written in this very cycle; bypass the RAM.
                        w_chardata_nxt = (w_str_wr && r_str_len == '0) ? wr_data
                                                                        : r_str_mem[0];
                    end
                end
            end
            StSendStr: begin
                if (r_idx == r_str_len - StrLenW'(1)) begin
                    w_state_nxt     = StSendPat;
                    w_idx_nxt       = '0;
                    w_ispattern_nxt = 1'b1;
                    w_chardata_nxt  = r_pat_mem[0];
                end else begin
                    w_idx_nxt      = w_idx_inc;
                    w_isstring_nxt = 1'b1;
                    w_chardata_nxt = r_str_mem[w_idx_inc[StrAw-1:0]];
                end
            end
            StSendPat: begin
                if (r_idx == StrLenW'(r_pat_len - PatLenW'(1))) begin
                    w_state_nxt = StGap;
                end else begin
                    w_idx_nxt       = w_idx_inc;
                    w_ispattern_nxt = 1'b1;
                    w_chardata_nxt  = r_pat_mem[w_idx_inc[PatAw-1:0]];
                end
            end
            StGap: w_state_nxt = StWait;
            StWait: begin
                if (valid) begin
                    w_state_nxt = StDone;
                    w_done_nxt  = 1'b1;
                    w_cap_valid = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state_nxt = StDone;
                    w_done_nxt  = 1'b1;
                    w_cap_tmo   = 1'b1;
                end
            end
            StDone: begin
                w_state_nxt   = StIdle;
                w_idx_nxt     = '0;
                w_str_len_nxt = '0;
                w_pat_len_nxt = '0;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_str_len   <= '0;
            r_pat_len   <= '0;
            r_chardata  <= 8'h00;
            r_isstring  <= 1'b0;
            r_ispattern <= 1'b0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_res_match <= 1'b0;
            r_res_index <= 5'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_str_len   <= w_str_len_nxt;
            r_pat_len   <= w_pat_len_nxt;
            r_chardata  <= w_chardata_nxt;
            r_isstring  <= w_isstring_nxt;
            r_ispattern <= w_ispattern_nxt;
            r_err       <= w_err_nxt;
            r_done      <= w_done_nxt;
            if (w_cap_valid) begin
                r_res_match <= match;
                r_res_index <= match_index;
            end else if (w_cap_tmo) begin
                r_res_match <= 1'b0;
                r_res_index <= 5'd0;
            end
        end
    end

    // Buffer RAM carries no reset.
    always_ff @(posedge clk) begin
        if (!reset && w_str_wr) r_str_mem[r_str_len[StrAw-1:0]] <= wr_data;
        if (!reset && w_pat_wr) r_pat_mem[r_pat_len[PatAw-1:0]] <= wr_data;
    end

`ifdef SME_HOST_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    logic [TmoW-1:0] r_tmo_cnt;
    logic            r_res_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt     <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_tmo_cnt <= (r_state == StWait) ? r_tmo_cnt + TmoW'(1) : '0;
            if (w_cap_valid)    r_res_timeout <= 1'b0;
            else if (w_cap_tmo) r_res_timeout <= 1'b1;
        end
    end

    assign w_tmo_hit   = (r_tmo_cnt == TmoW'(TIMEOUT_CYC - 1));
    assign res_timeout = r_res_timeout;
`else
    assign w_tmo_hit   = 1'b0;
    assign res_timeout = 1'b0;
`endif

    assign busy      = (r_state != StIdle);
    assign done      = r_done;
    assign err       = r_err;
    assign res_match = r_res_match;
    assign res_index = r_res_index;
    assign chardata  = r_chardata;
    assign isstring  = r_isstring;
    assign ispattern = r_ispattern;

endmodule

// File: tb/tb_sme_host.sv
// Scoreboard bench for sme_host: expected beats are queued at start and popped as the
// DUT emits qualified bytes; result, err and done timing are checked cycle-exactly.
module tb_sme_host;

    logic       clk = 1'b0;
    logic       reset, wr_en, wr_sel, start, valid, match;
    logic [7:0] wr_data;
    logic [4:0] match_index;
    logic       busy, done, err, res_match, res_timeout, isstring, ispattern;
    logic [4:0] res_index;
    logic [7:0] chardata;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_done   = 0;
    int         n_err    = 0;
    logic [9:0] exp_q[$];
    logic [7:0] mdl_str[$];
    logic [7:0] mdl_pat[$];
    logic [9:0] mon_exp;

    sme_host #(
        .STR_DEPTH  (32),
        .PAT_DEPTH  (8),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .res_match  (res_match),
        .res_index  (res_index),
        .res_timeout(res_timeout),
        .chardata   (chardata),
        .isstring   (isstring),
        .ispattern  (ispattern),
        .valid      (valid),
        .match      (match),
        .match_index(match_index)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Beat monitor: every qualified byte must match the head of the scoreboard.
    always @(negedge clk) begin
        if (done) n_done++;
        if (err) n_err++;
        if (isstring || ispattern) begin
            if (exp_q.size() == 0) begin
                check_eq("beat_extra", {22'b0, isstring, ispattern, chardata}, 32'h0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("beat", {22'b0, isstring, ispattern, chardata}, {22'b0, mon_exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(input bit sel, input logic [7:0] d);
        if (!sel && mdl_str.size() < 32) mdl_str.push_back(d);
        if (sel && mdl_pat.size() < 8) mdl_pat.push_back(d);
    endtask

    task automatic wr_byte(input bit sel, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_data = d;
        model_push(sel, d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wr_str(input bit sel, input string s);
        for (int i = 0; i < s.len(); i++) wr_byte(sel, s[i]);
    endtask

    task automatic run_txn(input string tag, input bit use_valid, input bit m,
                           input logic [4:0] idx, input int vdly, input bit wr_with_start,
                           input bit ws_sel, input logic [7:0] ws_data);
        int s;
        int p;
        int done0;
        if (wr_with_start) begin
            wr_en   = 1'b1;
            wr_sel  = ws_sel;
            wr_data = ws_data;
            model_push(ws_sel, ws_data);
        end
        s = mdl_str.size();
        p = mdl_pat.size();
        foreach (mdl_str[i]) exp_q.push_back({2'b10, mdl_str[i]});
        foreach (mdl_pat[i]) exp_q.push_back({2'b01, mdl_pat[i]});
        done0 = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        check_eq({tag, "_busy_t1"}, 32'(busy), 32'h1);
        check_eq({tag, "_err_t1"}, 32'(err), 32'h0);
        repeat (s + p) tick();
        check_eq({tag, "_gap"}, {22'b0, isstring, ispattern, chardata}, 32'h0);
        check_eq({tag, "_beats_left"}, 32'(exp_q.size()), 32'h0);
        tick();
        if (use_valid) begin
            repeat (vdly) tick();
            check_eq({tag, "_done_early"}, 32'(done), 32'h0);
            valid       = 1'b1;
            match       = m;
            match_index = idx;
            tick();
            valid       = 1'b0;
            match       = 1'b0;
            match_index = 5'd0;
            check_eq({tag, "_done"}, 32'(done), 32'h1);
            check_eq({tag, "_res_match"}, 32'(res_match), 32'(m));
            check_eq({tag, "_res_index"}, 32'(res_index), 32'(idx));
            check_eq({tag, "_res_timeout"}, 32'(res_timeout), 32'h0);
            check_eq({tag, "_busy_done"}, 32'(busy), 32'h1);
        end else begin
            repeat (15) tick();
            check_eq({tag, "_done_early"}, 32'(done), 32'h0);
            tick();
            check_eq({tag, "_done"}, 32'(done), 32'h1);
            check_eq({tag, "_res_timeout"}, 32'(res_timeout), 32'h1);
            check_eq({tag, "_res_match"}, 32'(res_match), 32'h0);
            check_eq({tag, "_res_index"}, 32'(res_index), 32'h0);
        end
        tick();
        check_eq({tag, "_done_after"}, 32'(done), 32'h0);
        check_eq({tag, "_busy_after"}, 32'(busy), 32'h0);
        check_eq({tag, "_done_count"}, 32'(n_done - done0), 32'h1);
        mdl_str.delete();
        mdl_pat.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit reached, expected end of test");
        $fatal(1);
    end

    initial begin
        int err0;
        int done0;
        reset       = 1'b1;
        wr_en       = 1'b0;
        wr_sel      = 1'b0;
        wr_data     = 8'h00;
        start       = 1'b0;
        valid       = 1'b0;
        match       = 1'b0;
        match_index = 5'd0;
        repeat (3) tick();
        check_eq("reset_outs", {13'b0, busy, done, err, res_match, res_index, res_timeout,
                 chardata, isstring, ispattern}, 32'h0);
        reset = 1'b0;
        tick();

        // Basic match, valid arrives a few cycles into WAIT.
        wr_str(1'b0, "hello world");
        wr_str(1'b1, "wor");
        run_txn("hello", 1'b1, 1'b1, 5'd6, 3, 1'b0, 1'b0, 8'h00);

        // Anchors sent verbatim; final '$' written in the same cycle as start.
        wr_str(1'b0, "ab");
        wr_str(1'b1, "^ab");
        run_txn("anchor", 1'b1, 1'b0, 5'd0, 0, 1'b1, 1'b1, 8'h24);

        // Start with empty pattern is rejected; string survives for the next start.
        wr_str(1'b0, "xyz");
        err0  = n_err;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("nopat_err", 32'(err), 32'h1);
        check_eq("nopat_busy", 32'(busy), 32'h0);
        check_eq("nopat_qual", {30'b0, isstring, ispattern}, 32'h0);
        tick();
        check_eq("nopat_err_clr", 32'(err), 32'h0);
        check_eq("nopat_err_count", 32'(n_err - err0), 32'h1);
        wr_str(1'b1, "y");
        run_txn("after_err", 1'b1, 1'b1, 5'd1, 1, 1'b0, 1'b0, 8'h00);

        // Overfill both buffers; extra bytes must not appear on the bus.
        for (int i = 0; i < 33; i++) wr_byte(1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 9; i++) wr_byte(1'b1, 8'(8'hA0 + i));
        run_txn("full", 1'b1, 1'b1, 5'd31, 2, 1'b0, 1'b0, 8'h00);

        // Reset during the 5th string beat.
        wr_str(1'b0, "abcdefgh");
        wr_str(1'b1, "z");
        foreach (mdl_str[i]) exp_q.push_back({2'b10, mdl_str[i]});
        foreach (mdl_pat[i]) exp_q.push_back({2'b01, mdl_pat[i]});
        done0 = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check_eq("rst_beat5", {22'b0, isstring, ispattern, chardata}, {22'b0, 2'b10, 8'h65});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst_qual", {30'b0, isstring, ispattern}, 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        exp_q.delete();
        mdl_str.delete();
        mdl_pat.delete();
        repeat (20) tick();
        check_eq("rst_no_done", 32'(n_done - done0), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("rst_len_zero_err", 32'(err), 32'h1);
        tick();
        wr_str(1'b0, "cat");
        wr_str(1'b1, "a");
        run_txn("post_rst", 1'b1, 1'b1, 5'd1, 0, 1'b0, 1'b0, 8'h00);

`ifdef SME_HOST_TIMEOUT_EN
        wr_str(1'b0, "q");
        wr_str(1'b1, "q");
        run_txn("tmo", 1'b0, 1'b0, 5'd0, 0, 1'b0, 1'b0, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
